contador_seq_param: RTL and testbench

Parametrised up/down sequence counter with a built-in prescaler, synchronous load, wrap/turnaround flag and hex seven-segment output. It generalises the fixed divide-by-3, 8-state up/down display counter to arbitrary divide ratio, state count and width. It adds load and an optional ping-pong mode. It sits between the board clock/switch inputs and the seven-segment pins.

---
 rtl/contador_seq_param.sv | 169 ++++++++++++++++
 tb/tb_contador_seq_param.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : contador_seq_param
// Brief    : Parametrised up/down sequence counter with prescaler, synchronous
//            load, wrap/turnaround pulse and hex seven-segment decode.
// Options  : define CONTADOR_SEQ_PINGPONG_EN to build the ping-pong mode;
//            without it the mode input is ignored and no dir register exists.
// Revision : 1.0 - initial release
// ============================================================================
module contador_seq_param #(
  parameter int DIV = 3,
  parameter int MOD = 8,
  parameter int W   = 3
) (
  input  logic         eck,
  input  logic         er,
  input  logic         eena,
  input  logic         down,
  input  logic         mode,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] estado,
  output logic         tick,
  output logic         wrap,
  output logic         A,
  output logic         B,
  output logic         C,
  output logic         D,
  output logic         E,
  output logic         F,
  output logic         G
);

  localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] c_pre_last = PW'(DIV - 1);
  localparam logic [W-1:0]  c_last     = W'(MOD - 1);

  logic [PW-1:0] r_pre;
  logic [W-1:0]  r_estado;
  logic          r_wrap;
  logic [W-1:0]  w_step_next;
  logic          w_step_wrap;
  logic [W-1:0]  w_ld_sat;
  logic          w_pp;
  logic          w_eff_down;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;

  assign tick     = eena & (r_pre == c_pre_last);
  assign estado   = r_estado;
  assign wrap     = r_wrap;
  assign w_ld_sat = (ld_val > c_last) ? c_last : ld_val;

`ifdef CONTADOR_SEQ_PINGPONG_EN
  logic r_dir;

  assign w_pp       = mode;
  assign w_eff_down = mode ? r_dir : down;

  // Direction flag: mirrors down in normal mode, flips on each ping-pong reversal
  always_ff @(posedge eck) begin
    if (er) begin
      r_dir <= 1'b0;
    end else if (!ld) begin
      if (!mode) begin
        r_dir <= down;
      end else if (w_step_wrap) begin
        r_dir <= ~r_dir;
      end
    end
  end
`else
  logic w_unused_mode;

  assign w_pp          = 1'b0;
  assign w_eff_down    = down;
  assign w_unused_mode = mode;
`endif

  // Prescaler: counts enabled edges, returns to zero on the step edge or a load
  always_ff @(posedge eck) begin
    if (er || ld) begin
      r_pre <= '0;
    end else if (eena) begin
      r_pre <= (r_pre == c_pre_last) ? '0 : r_pre + PW'(1);
    end
  end

  // Next count value and wrap/reversal event for a step taken this edge
  always_comb begin
    w_step_next = r_estado;
    w_step_wrap = 1'b0;
    if (tick) begin
      if (!w_eff_down) begin
        if (r_estado == c_last) begin
          w_step_wrap = 1'b1;
          if (w_pp) begin
            // bounce back one state; a single-state sequence stays put
            w_step_next = (MOD == 1) ? '0 : r_estado - W'(1);
          end else begin
            w_step_next = '0;
          end
        end else begin
          w_step_next = r_estado + W'(1);
        end
      end else begin
        if (r_estado == '0) begin
          w_step_wrap = 1'b1;
          if (w_pp) begin
            w_step_next = (MOD == 1) ? '0 : r_estado + W'(1);
          end else begin
            w_step_next = c_last;
          end
        end else begin
          w_step_next = r_estado - W'(1);
        end
      end
    end
  end

  // Count state and registered wrap pulse; load overrides the step
  always_ff @(posedge eck) begin
    if (er) begin
      r_estado <= '0;
      r_wrap   <= 1'b0;
    end else if (ld) begin
      r_estado <= w_ld_sat;
      r_wrap   <= 1'b0;
    end else begin
      r_estado <= w_step_next;
      r_wrap   <= w_step_wrap;
    end
  end

  // Low nibble of the state, zero-extended for narrow counters
  if (W >= 4) begin : g_nib_wide
    assign w_nib = r_estado[3:0];
  end else begin : g_nib_narrow
    assign w_nib = {{(4 - W){1'b0}}, r_estado};
  end

  // Hex glyph decode, segment order {A,B,C,D,E,F,G}
  always_comb begin
    w_seg = 7'b1111110;
    case (w_nib)
      4'h0: w_seg = 7'b1111110;
      4'h1: w_seg = 7'b0110000;
      4'h2: w_seg = 7'b1101101;
      4'h3: w_seg = 7'b1111001;
      4'h4: w_seg = 7'b0110011;
      4'h5: w_seg = 7'b1011011;
      4'h6: w_seg = 7'b1011111;
      4'h7: w_seg = 7'b1110000;
      4'h8: w_seg = 7'b1111111;
      4'h9: w_seg = 7'b1111011;
      4'hA: w_seg = 7'b1110111;
      4'hB: w_seg = 7'b0011111;
      4'hC: w_seg = 7'b1001110;
      4'hD: w_seg = 7'b0111101;
      4'hE: w_seg = 7'b1001111;
      4'hF: w_seg = 7'b1000111;
      default: w_seg = 7'b1111110;
    endcase
  end

  assign {A, B, C, D, E, F, G} = w_seg;

endmodule
`default_nettype wire

// File: tb/tb_contador_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_seq_param
// Brief    : Self-checking bench for contador_seq_param. Three instances share
//            one stimulus stream: (DIV,MOD,W) = (3,8,3), (1,8,4), (1,4,2).
//            Honours CONTADOR_SEQ_PINGPONG_EN for the expected behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_contador_seq_param;

`ifdef CONTADOR_SEQ_PINGPONG_EN
  localparam int PINGPONG = 1;
`else
  localparam int PINGPONG = 0;
`endif

  logic       eck = 1'b0;
  logic       er = 1'b0, eena = 1'b0, down = 1'b0, mode = 1'b0, ld = 1'b0;
  logic [3:0] ld_val = 4'd0;
  logic [2:0] est0;
  logic [3:0] est1;
  logic [1:0] est2;
  logic       tick0, tick1, tick2, wrap0, wrap1, wrap2;
  logic [6:0] seg0, seg1, seg2;

  always #5 eck = ~eck;

  contador_seq_param #(.DIV(3), .MOD(8), .W(3)) u_dut0 (
    .eck(eck), .er(er), .eena(eena), .down(down), .mode(mode), .ld(ld),
    .ld_val(ld_val[2:0]), .estado(est0), .tick(tick0), .wrap(wrap0),
    .A(seg0[6]), .B(seg0[5]), .C(seg0[4]), .D(seg0[3]), .E(seg0[2]),
    .F(seg0[1]), .G(seg0[0]));

  contador_seq_param #(.DIV(1), .MOD(8), .W(4)) u_dut1 (
    .eck(eck), .er(er), .eena(eena), .down(down), .mode(mode), .ld(ld),
    .ld_val(ld_val), .estado(est1), .tick(tick1), .wrap(wrap1),
    .A(seg1[6]), .B(seg1[5]), .C(seg1[4]), .D(seg1[3]), .E(seg1[2]),
    .F(seg1[1]), .G(seg1[0]));

  contador_seq_param #(.DIV(1), .MOD(4), .W(2)) u_dut2 (
    .eck(eck), .er(er), .eena(eena), .down(down), .mode(mode), .ld(ld),
    .ld_val(ld_val[1:0]), .estado(est2), .tick(tick2), .wrap(wrap2),
    .A(seg2[6]), .B(seg2[5]), .C(seg2[4]), .D(seg2[3]), .E(seg2[2]),
    .F(seg2[1]), .G(seg2[0]));

  typedef struct {
    bit       er;
    bit       eena;
    bit       down;
    bit       mode;
    bit       ld;
    bit [3:0] ldv;
    int       inst;      // instance whose table expectations apply, -1 none
    int       exp_est;   // -1 = not checked
    int       exp_wrap;
    int       exp_seg;
  } vec_t;

  vec_t  vecs[$];
  int    n_chk = 0;
  int    n_pass = 0;

  // Reference model state, one slot per instance
  int    c_div[3] = '{3, 1, 1};
  int    c_mod[3] = '{8, 8, 4};
  int    c_wm[3]  = '{7, 15, 3};
  int    m_est[3], m_pre[3], m_dir[3], m_wrap[3];
  bit    m_valid = 1'b0;

  string glyphs[16] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG",
                        "ACDEFG", "ABC", "ABCDEFG", "ABCDFG", "ABCEFG",
                        "CDEFG", "ADEF", "BCDEG", "ADEFG", "AEFG"};

  function automatic logic [31:0] glyph(int n);
    logic [31:0] r = 32'd0;
    string s = glyphs[n % 16];
    for (int k = 0; k < s.len(); k++) r[6 - (int'(s[k]) - 65)] = 1'b1;
    return r;
  endfunction

  function automatic void check(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", name, i, act, exp, $time);
  endfunction

  function automatic logic [31:0] act_est(int i);
    case (i)
      0: return 32'(est0);
      1: return 32'(est1);
      default: return 32'(est2);
    endcase
  endfunction

  function automatic logic [31:0] act_tick(int i);
    case (i)
      0: return 32'(tick0);
      1: return 32'(tick1);
      default: return 32'(tick2);
    endcase
  endfunction

  function automatic logic [31:0] act_wrap(int i);
    case (i)
      0: return 32'(wrap0);
      1: return 32'(wrap1);
      default: return 32'(wrap2);
    endcase
  endfunction

  function automatic logic [31:0] act_seg(int i);
    case (i)
      0: return 32'(seg0);
      1: return 32'(seg1);
      default: return 32'(seg2);
    endcase
  endfunction

  function automatic bit m_tick(int i);
    return (eena === 1'b1) && (m_pre[i] == c_div[i] - 1);
  endfunction

  // Behavioural update: signed step on an integer position, range checks
  function automatic void model_edge(int i);
    int d, n;
    bit t, pp;
    t = m_tick(i);
    if (er === 1'b1) begin
      m_est[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_dir[i] = 0;
    end else if (ld === 1'b1) begin
      n = int'(ld_val) & c_wm[i];
      m_est[i]  = (n > c_mod[i] - 1) ? c_mod[i] - 1 : n;
      m_pre[i]  = 0;
      m_wrap[i] = 0;
    end else begin
      if (eena === 1'b1) m_pre[i] = t ? 0 : m_pre[i] + 1;
      pp = (PINGPONG != 0) && (mode === 1'b1);
      m_wrap[i] = 0;
      if (t) begin
        if (pp) d = (m_dir[i] != 0) ? -1 : 1;
        else    d = (down === 1'b1) ? -1 : 1;
        n = m_est[i] + d;
        if (n < 0 || n >= c_mod[i]) begin
          m_wrap[i] = 1;
          if (pp) begin
            m_dir[i] = (m_dir[i] != 0) ? 0 : 1;
            n = m_est[i] - d;
            if (n < 0 || n >= c_mod[i]) n = m_est[i];
          end else begin
            n = (n + c_mod[i]) % c_mod[i];
          end
        end
        m_est[i] = n;
      end
      if (!pp) m_dir[i] = (down === 1'b1) ? 1 : 0;
    end
  endfunction

  function automatic void add(bit r, bit en, bit dn, bit md, bit l, bit [3:0] lv,
                              int inst, int ee, int ew, int es);
    vec_t v;
    v.er = r; v.eena = en; v.down = dn; v.mode = md; v.ld = l; v.ldv = lv;
    v.inst = inst; v.exp_est = ee; v.exp_wrap = ew; v.exp_seg = es;
    vecs.push_back(v);
  endfunction

  function automatic void add_run(int n, bit en, bit dn, bit md);
    for (int k = 0; k < n; k++) add(1'b0, en, dn, md, 1'b0, 4'd0, -1, -1, -1, -1);
  endfunction

  task automatic run_vec(input vec_t v);
    er = v.er; eena = v.eena; down = v.down; mode = v.mode; ld = v.ld;
    ld_val = v.ldv;
    #1;
    if (m_valid)
      for (int i = 0; i < 3; i++) check("tick", i, act_tick(i), 32'(m_tick(i)));
    @(posedge eck);
    for (int i = 0; i < 3; i++) model_edge(i);
    if (v.er) m_valid = 1'b1;
    #1;
    if (m_valid) begin
      for (int i = 0; i < 3; i++) begin
        check("estado", i, act_est(i), 32'(m_est[i]));
        check("wrap", i, act_wrap(i), 32'(m_wrap[i]));
        check("segments", i, act_seg(i), glyph(m_est[i]));
      end
    end
    if (v.inst >= 0) begin
      if (v.exp_est >= 0) check("vec_estado", v.inst, act_est(v.inst), 32'(v.exp_est));
      if (v.exp_wrap >= 0) check("vec_wrap", v.inst, act_wrap(v.inst), 32'(v.exp_wrap));
      if (v.exp_seg >= 0) check("vec_segments", v.inst, act_seg(v.inst), 32'(v.exp_seg));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pp_e[7];
    int pp_w[7];
    bit r_mode = 1'b0, r_down = 1'b0;
    vec_t v;

`ifdef CONTADOR_SEQ_PINGPONG_EN
    pp_e = '{1, 2, 3, 2, 1, 0, 1};
    pp_w = '{0, 0, 0, 1, 0, 0, 1};
`else
    pp_e = '{1, 2, 3, 0, 1, 2, 3};
    pp_w = '{0, 0, 0, 1, 0, 0, 0};
`endif

    // count-up latency and wrap, DIV=3 MOD=8
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111110);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, -1);
    add_run(2, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 2, 0, -1);
    add_run(17, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, -1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    // count-down, DIV=1 MOD=8
    add(1, 0, 1, 0, 0, 0, 1, 0, 0, 7'b1111110);
    add(0, 1, 1, 0, 0, 0, 1, 7, 1, -1);
    add(0, 1, 1, 0, 0, 0, 1, 6, 0, -1);
    add(0, 1, 1, 0, 0, 0, 1, 5, 0, 7'b1011011);
    // prescaler stall
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, -1);
    // load, saturation and reset-over-load
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    add_run(1, 1, 0, 0);
    add(0, 1, 0, 0, 1, 5, 0, 5, 0, -1);
    add(0, 1, 0, 0, 0, 0, 0, 5, 0, -1);
    add(0, 1, 0, 0, 0, 0, 0, 5, 0, -1);
    add(0, 1, 0, 0, 0, 0, 0, 6, 0, -1);
    add(0, 1, 0, 0, 1, 7, 0, 7, 0, -1);
    add(0, 1, 0, 0, 1, 9, 1, 7, 0, -1);
    add(1, 1, 0, 0, 1, 5, 0, 0, 0, -1);
    // ping-pong from reset, DIV=1 MOD=4
    add(1, 0, 0, 1, 0, 0, 2, 0, 0, -1);
    for (int k = 0; k < 7; k++) add(0, 1, 0, 1, 0, 0, 2, pp_e[k], pp_w[k], -1);
    // reset mid-operation at estado=6, pre=1
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    add_run(18, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 6, 0, -1);
    add(1, 1, 0, 0, 1, 3, 0, 0, 0, 7'b1111110);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, -1);

    foreach (vecs[k]) run_vec(vecs[k]);

    // randomized traffic against the reference model
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(15) == 0) r_mode = ~r_mode;
      if ($urandom_range(9) == 0) r_down = ~r_down;
      v.er       = ($urandom_range(59) == 0);
      v.ld       = ($urandom_range(11) == 0);
      v.eena     = ($urandom_range(7) != 0);
      v.mode     = r_mode;
      v.down     = r_down;
      v.ldv      = 4'($urandom_range(15));
      v.inst     = -1;
      v.exp_est  = -1;
      v.exp_wrap = -1;
      v.exp_seg  = -1;
      run_vec(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
